// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states and grant encoding.
package mem_arb_pkg;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_CAM  = 2'd2
  } grant_t;

endpackage

// File: rtl/cam_wfifo.sv
// Camera write buffer: circular FIFO of {addr, data} with per-entry valid bits
// and a combinational "any valid entry matches query_addr" output.
module cam_wfifo #(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic [ADDR_W-1:0] query_addr,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level,
  output logic              match
);

  logic [PTR_W:0]      head_reg;
  logic [PTR_W:0]      tail_reg;
  logic [LVL_W-1:0]    level_reg;
  logic [PTR_W-1:0]    head_idx;
  logic [PTR_W-1:0]    tail_idx;
  logic                do_push;
  logic                do_pop;
  logic [ADDR_W-1:0]   addr_arr [DEPTH];
  logic [DATA_W-1:0]   data_arr [DEPTH];
  logic [DEPTH-1:0]    hit_vec;

  assign head_idx = head_reg[PTR_W-1:0];
  assign tail_idx = tail_reg[PTR_W-1:0];

  // Same slot index with opposite wrap bits means the tail has lapped the head.
  assign empty = (head_reg == tail_reg);
  assign full  = (head_idx == tail_idx) && (head_reg[PTR_W] != tail_reg[PTR_W]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_addr = addr_arr[head_idx];
  assign head_data = data_arr[head_idx];
  assign level     = level_reg;
  assign match     = |hit_vec;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [ADDR_W-1:0] entry_addr_reg;
      logic [DATA_W-1:0] entry_data_reg;
      logic              entry_valid_reg;
      logic              wr_en;
      logic              clr_en;

      assign wr_en  = do_push && (tail_idx == PTR_W'(gi));
      assign clr_en = do_pop && (head_idx == PTR_W'(gi));

      always_ff @(posedge clk) begin
        if (reset) begin
          entry_valid_reg <= 1'b0;
        end else if (wr_en) begin
          entry_addr_reg  <= push_addr;
          entry_data_reg  <= push_data;
          entry_valid_reg <= 1'b1;
        end else if (clr_en) begin
          entry_valid_reg <= 1'b0;
        end
      end

      assign addr_arr[gi] = entry_addr_reg;
      assign data_arr[gi] = entry_data_reg;
      assign hit_vec[gi]  = entry_valid_reg && (entry_addr_reg == query_addr);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      level_reg <= '0;
    end else begin
      if (do_push) begin
        tail_reg <= tail_reg + 1'b1;
      end
      if (do_pop) begin
        head_reg <= head_reg + 1'b1;
      end
      level_reg <= level_reg + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU memory stage has priority, buffered camera
// writes drain on idle cycles, on address hits, or in a forced anti-starvation slot.
module dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int ADDR_W       = 32,
  parameter  int DATA_W       = 32,
  parameter  int FIFO_DEPTH   = 4,
  parameter  int CAM_MAX_WAIT = 8,
  localparam int LVL_W        = $clog2(FIFO_DEPTH + 1),
  localparam int WAIT_W       = $clog2(CAM_MAX_WAIT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              cam_valid,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [DATA_W-1:0] cam_data,
  output logic              cam_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [LVL_W-1:0]  fifo_level
);

  arb_state_t        state_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  grant_t            grant;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_match;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              hit;

  cam_wfifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_wfifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_addr  (cam_addr),
    .push_data  (cam_data),
    .pop        (fifo_pop),
    .query_addr (cpu_addr),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (fifo_level),
    .match      (fifo_match)
  );

  assign cam_ready = !fifo_full && !reset;
  assign fifo_push = cam_valid && cam_ready;
  assign hit       = cpu_req && fifo_match;
  assign cpu_rdata = mem_rdata;

  // A hit implies a non-empty FIFO, so the hit case and the idle-drain case
  // share the same "pop the head" branch.
  always_comb begin
    grant = GNT_NONE;
    if (!reset) begin
      if (state_reg == FORCE) begin
        if (!fifo_empty) grant = GNT_CAM;
      end else if (cpu_req && !hit) begin
        grant = GNT_CPU;
      end else if (!fifo_empty) begin
        grant = GNT_CAM;
      end
    end
  end

  assign fifo_pop = (grant == GNT_CAM);

  always_comb begin
    cpu_stall = 1'b0;
    if (!reset) begin
      cpu_stall = (state_reg == FORCE) ? cpu_req : hit;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    unique case (grant)
      GNT_CPU: mem_we = cpu_we;
      GNT_CAM: begin
        mem_we    = 1'b1;
        mem_addr  = head_addr;
        mem_wdata = head_data;
      end
      default: mem_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= NORMAL;
      wait_cnt_reg <= '0;
    end else begin
      unique case (state_reg)
        NORMAL: begin
          if (fifo_pop || fifo_empty) begin
            wait_cnt_reg <= '0;
          end else if (wait_cnt_reg != WAIT_W'(CAM_MAX_WAIT)) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
          if (!fifo_pop && !fifo_empty && (wait_cnt_reg == WAIT_W'(CAM_MAX_WAIT - 1))) begin
            state_reg <= FORCE;
          end
        end
        FORCE: begin
          wait_cnt_reg <= '0;
          state_reg    <= NORMAL;
        end
        default: begin
          wait_cnt_reg <= '0;
          state_reg    <= NORMAL;
        end
      endcase
    end
  end

endmodule
